leaf_user_bridge: RTL
=====================

# leaf_user_bridge

Parametrised buffering bridge between a leaf's `leaf_interface` user-side ports and an HLS kernel with AXI-stream ports and `ap_ctrl_hs` control. It replaces the per-leaf direct wire-through with a per-channel FIFO on every input and output stream, and adds a start/drain controller that holds the kernel start until the kernel acknowledges it. The controller reports completion only after all output data has left the leaf. Per-output saturating word counters are kept for debug.

## Interface
- PAYLOAD_BITS, 32, data width per stream
- NUM_IN_PORTS, 4, interface→kernel streams (≥1)
- NUM_OUT_PORTS, 1, kernel→interface streams (≥1)
- FIFO_DEPTH_BITS, 2, log2 FIFO depth per stream (depth 4, ≥1)
- CNT_BITS, 16, width of each output word counter

Ports (flat buses; stream k occupies bits [k*W +: W]):
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start_in  in  1  level start from `leaf_interface` (ap_start_user)
- done_out  out  1  one-cycle completion pulse
- busy  out  1  high in RUN or DRAIN
- if2u_data  in  NUM_IN_PORTS*PAYLOAD_BITS  data from interface
- if2u_vld  in  NUM_IN_PORTS  interface valid
- if2u_ack  out  NUM_IN_PORTS  bridge ready to interface
- u_in_tdata  out  NUM_IN_PORTS*PAYLOAD_BITS  kernel Input TDATA
- u_in_tvalid  out  NUM_IN_PORTS  kernel Input TVALID
- u_in_tready  in  NUM_IN_PORTS  kernel Input TREADY
- u_out_tdata  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel Output TDATA
- u_out_tvalid  in  NUM_OUT_PORTS  kernel Output TVALID
- u_out_tready  out  NUM_OUT_PORTS  bridge ready to kernel
- u2if_data  out  NUM_OUT_PORTS*PAYLOAD_BITS  data to interface
- u2if_vld  out  NUM_OUT_PORTS  bridge valid to interface
- u2if_ack  in  NUM_OUT_PORTS  interface accept
- ap_start_kernel  out  1  kernel ap_start
- ap_ready_kernel  in  1  kernel ap_ready
- ap_done_kernel  in  1  kernel ap_done
- ap_rst_n_kernel  out  1  equals ~reset (combinational)
- out_word_cnt  out  NUM_OUT_PORTS*CNT_BITS  per-output words delivered to interface

## Operation
- Each stream has an independent synchronous FIFO with depth D = 2^FIFO_DEPTH_BITS. The occupancy count is FIFO_DEPTH_BITS+1 bits wide. Read and write pointers wrap modulo D.
- Input FIFOs:
  - Push on if2u_vld & if2u_ack, with if2u_ack = !full.
  - u_in_tvalid = !empty; u_in_tdata is the head entry.
  - Pop on tvalid & tready.
- Output FIFOs:
  - Push on u_out_tvalid & u_out_tready, with u_out_tready = !full.
  - u2if_vld = !empty; u2if_data is the head entry.
  - Pop on vld & u2if_ack.
- Simultaneous push and pop:
  - When not full and not empty, both occur and the count is unchanged.
  - When empty, the push is accepted and the pop cannot occur because valid is low.
  - When full, the push is refused because ready is low, and the pop proceeds.
- FIFOs move data in every FSM state; the FSM gates only control signals.
- FSM, states IDLE, RUN, DRAIN:
  - IDLE: when start_in = 1, go to RUN, set ap_start_kernel = 1, and clear all out_word_cnt.
  - RUN: hold ap_start_kernel until ap_ready_kernel = 1 is sampled, then clear it the next cycle. When ap_done_kernel = 1, go to DRAIN; if ap_ready_kernel is high in the same cycle, clear ap_start_kernel too.
  - DRAIN: when all output FIFOs are empty, go to IDLE and pulse done_out for exactly one cycle.
  - start_in that is still high on return to IDLE starts a new run on the following cycle.
- out_word_cnt[k] increments on each u2if pop of stream k and saturates at 2^CNT_BITS−1.

## Timing
- Reset is synchronous. The first clk edge with reset = 1 establishes the reset state:
  - All FIFOs empty, so u_in_tvalid = 0, u2if_vld = 0, if2u_ack = all 1, u_out_tready = all 1.
  - FSM in IDLE, ap_start_kernel = 0, busy = 0, done_out = 0, out_word_cnt = 0.
  - FIFO contents are discarded.
- Reset asserted mid-run behaves identically to reset from IDLE: all buffered words are dropped and no done_out is produced.
- FIFO latency: a word pushed at edge t is presented on the far side during cycle t+1, giving a first-word latency of 1 cycle.
- Full throughput of one word per cycle per stream is sustained when the far side is always ready.
- ack/tready depend only on registered occupancy, with no combinational path from the far side.
- done_out is asserted in the cycle after the edge at which DRAIN observes all output FIFOs empty.
- The earliest done_out is 2 cycles after ap_done_kernel when output FIFOs are empty.

## Test plan
- Reset, then idle: all outputs match the reset values above. Assert reset for 1 cycle mid-transfer with 3 words buffered → u2if_vld = 0 next cycle and counters are 0.
- Stream 2 receives 0x11,0x22,0x33,0x44,0x55 with u_in_tready = 0 → if2u_ack[2] drops after 4 words. Raise tready → the kernel receives all 5 in order, and the other streams are unaffected.
- Output stream 0, kernel sends 10 words with u2if_ack toggling 1/0 → 10 words arrive in order, and out_word_cnt[0] = 10.
- Raise start_in, hold ap_ready_kernel = 0 for 5 cycles → ap_start_kernel stays high. It clears the cycle after ap_ready_kernel = 1.
- ap_done_kernel with 3 words left in output FIFO 0 and u2if_ack = 1 → busy stays high until the FIFO is empty, then a single-cycle done_out.
- CNT_BITS = 4 with 20 words delivered → out_word_cnt = 15. The next start clears it to 0.

Source files
------------

// File: rtl/leaf_user_bridge_if.sv
// Bundle of every handshake, data and control signal between the bridge, the leaf
// interface and the HLS kernel; slave is the bridge's view, master the surroundings'.
interface leaf_user_bridge_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 1,
  parameter int CNT_BITS      = 16
);
  logic                                    start_in;
  logic                                    done_out;
  logic                                    busy;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    if2u_data;
  logic [NUM_IN_PORTS-1:0]                 if2u_vld;
  logic [NUM_IN_PORTS-1:0]                 if2u_ack;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    u_in_tdata;
  logic [NUM_IN_PORTS-1:0]                 u_in_tvalid;
  logic [NUM_IN_PORTS-1:0]                 u_in_tready;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   u_out_tdata;
  logic [NUM_OUT_PORTS-1:0]                u_out_tvalid;
  logic [NUM_OUT_PORTS-1:0]                u_out_tready;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   u2if_data;
  logic [NUM_OUT_PORTS-1:0]                u2if_vld;
  logic [NUM_OUT_PORTS-1:0]                u2if_ack;
  logic                                    ap_start_kernel;
  logic                                    ap_ready_kernel;
  logic                                    ap_done_kernel;
  logic                                    ap_rst_n_kernel;
  logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_word_cnt;

  modport slave (
    input  start_in, if2u_data, if2u_vld, u_in_tready, u_out_tdata, u_out_tvalid,
           u2if_ack, ap_ready_kernel, ap_done_kernel,
    output done_out, busy, if2u_ack, u_in_tdata, u_in_tvalid, u_out_tready,
           u2if_data, u2if_vld, ap_start_kernel, ap_rst_n_kernel, out_word_cnt
  );

  modport master (
    output start_in, if2u_data, if2u_vld, u_in_tready, u_out_tdata, u_out_tvalid,
           u2if_ack, ap_ready_kernel, ap_done_kernel,
    input  done_out, busy, if2u_ack, u_in_tdata, u_in_tvalid, u_out_tready,
           u2if_data, u2if_vld, ap_start_kernel, ap_rst_n_kernel, out_word_cnt
  );
endinterface

// File: rtl/leaf_user_bridge.sv
// Per-stream FIFO bridge between leaf_interface user ports and an ap_ctrl_hs HLS kernel,
// with a start/drain controller and saturating per-output word counters.
module leaf_user_bridge_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_pop_ready
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // Handshakes come only from the registered count, so no far-side path reaches them.
  assign o_ready = (r_count != FULL_COUNT);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & o_ready;
  assign w_pop   = o_valid & i_pop_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module leaf_user_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 4,
  parameter int NUM_OUT_PORTS   = 1,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS        = 16
) (
  input  logic               clk,
  input  logic               reset,
  leaf_user_bridge_if.slave  bus
);
  localparam int W = PAYLOAD_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                   r_state;
  logic                     r_ap_start;
  logic                     r_done;
  logic [NUM_OUT_PORTS-1:0] w_out_vld;
  logic                     w_cnt_clr;

  assign w_cnt_clr           = (r_state == S_IDLE) & bus.start_in;
  assign bus.u2if_vld        = w_out_vld;
  assign bus.ap_start_kernel = r_ap_start;
  assign bus.done_out        = r_done;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.ap_rst_n_kernel = ~reset;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
      leaf_user_bridge_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (bus.if2u_vld[gi]),
        .i_data      (bus.if2u_data[gi*W +: W]),
        .o_ready     (bus.if2u_ack[gi]),
        .o_valid     (bus.u_in_tvalid[gi]),
        .o_data      (bus.u_in_tdata[gi*W +: W]),
        .i_pop_ready (bus.u_in_tready[gi])
      );
    end

    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      logic [CNT_BITS-1:0] r_cnt;

      leaf_user_bridge_fifo #(.WIDTH(W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (bus.u_out_tvalid[gi]),
        .i_data      (bus.u_out_tdata[gi*W +: W]),
        .o_ready     (bus.u_out_tready[gi]),
        .o_valid     (w_out_vld[gi]),
        .o_data      (bus.u2if_data[gi*W +: W]),
        .i_pop_ready (bus.u2if_ack[gi])
      );

      // A new run's clear takes priority over a delivery in the same cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_cnt_clr) begin
          r_cnt <= '0;
        end else if (w_out_vld[gi] && bus.u2if_ack[gi] && (r_cnt != '1)) begin
          r_cnt <= r_cnt + CNT_BITS'(1);
        end
      end

      assign bus.out_word_cnt[gi*CNT_BITS +: CNT_BITS] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ap_start <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_in) begin
            r_state    <= S_RUN;
            r_ap_start <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.ap_ready_kernel) r_ap_start <= 1'b0;
          if (bus.ap_done_kernel)  r_state    <= S_DRAIN;
        end
        S_DRAIN: begin
          if (bus.ap_ready_kernel) r_ap_start <= 1'b0;
          // Completion is reported only once every output word has left the leaf.
          if (w_out_vld == '0) begin
            r_state    <= S_IDLE;
            r_ap_start <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
